// File: rtl/fan_pkg.sv
// Shared types and helpers for the fan gear / battery core.
// Holds the LED mode encoding and gear/drain sizing functions.
package fan_pkg;

    typedef enum logic [1:0] {
        LED_OFF,
        LED_ON,
        LED_BLINK_SLOW,
        LED_BLINK_FAST
    } led_mode_e;

    function automatic int gear_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Gear 0 never drains; returning the base keeps the period non-zero.
    function automatic int unsigned drain_period(input int unsigned base, input int unsigned g);
        return (g == 0) ? base : (base >> (g - 1));
    endfunction

endpackage

// File: rtl/fan_power_core_period_tick.sv
// Free-running counter with a runtime period and synchronous clear.
// Emits a one-cycle wrap pulse in the cycle the count reaches period-1.
module period_tick #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] period,
    output logic         wrap
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // '>=' guards against a period shrinking below the current count.
    always_comb begin
        wrap    = en && (count_q >= (period - W'(1)));
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = wrap ? '0 : (count_q + W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fan_power_core.sv
// N-gear fan controller with battery charge/drain model, long-press power-off,
// low-battery gear limiting and a status LED mode encoder.
module fan_power_core
    import fan_pkg::*;
#(
    parameter int CLK_HZ           = 100,
    parameter int NUM_GEARS        = 3,
    parameter int BATT_W           = 8,
    parameter int BATT_MAX         = 99,
    parameter int LOW_THRESH       = 20,
    parameter int LONG_PRESS_TICKS = 200,
    parameter int CHG_PERIOD       = 50,
    parameter int DRAIN_BASE       = 200
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               btn,
    input  logic                               charge_en,
    output logic [$clog2(NUM_GEARS+1)-1:0]     gear,
    output logic [BATT_W-1:0]                  battery,
    output logic                               battery_empty,
    output logic                               battery_low,
    output logic                               battery_full,
    output logic                               led
);

    localparam int GW    = gear_w(NUM_GEARS);
    localparam int HW    = $clog2(LONG_PRESS_TICKS + 1);
    localparam int CNT_W = $clog2(DRAIN_BASE + CHG_PERIOD + CLK_HZ + 1);

    logic              btn_prev_q, long_done_q, chg_prev_q;
    logic              long_done_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic [GW-1:0]     gear_q, gear_d, gmax;
    logic [BATT_W-1:0] battery_q, battery_d;
    logic              empty_q, low_q, full_q;
    logic              empty_d, low_d, full_d;
    logic              led_q, led_d;
    led_mode_e         led_mode_q, led_mode_d;

    logic              charge_edge, release_evt, short_press, long_hit;
    logic              chg_wrap, drn_wrap, blink_wrap;
    logic              drn_en, drn_clr, blink_en, blink_clr;
    logic [CNT_W-1:0]  drn_period, blink_period;

    assign charge_edge = charge_en ^ chg_prev_q;
    assign release_evt = btn_prev_q && !btn;
    assign short_press = release_evt && !long_done_q;
    assign long_hit    = btn && (hold_cnt_q == HW'(LONG_PRESS_TICKS - 1));
    assign gmax        = (low_q && !charge_en) ? GW'(1) : GW'(NUM_GEARS);

    always_comb begin
        hold_cnt_d = '0;
        if (btn) begin
            hold_cnt_d = (hold_cnt_q == HW'(LONG_PRESS_TICKS)) ? hold_cnt_q : hold_cnt_q + HW'(1);
        end
        long_done_d = long_done_q;
        if (long_hit) begin
            long_done_d = 1'b1;
        end else if (release_evt) begin
            long_done_d = 1'b0;
        end
    end

    // Battery model: charging has priority; the wrap pulses do not depend on gear_d.
    always_comb begin
        battery_d = battery_q;
        if (chg_wrap && (battery_q != BATT_W'(BATT_MAX))) begin
            battery_d = battery_q + BATT_W'(1);
        end else if (drn_wrap && (battery_q != '0)) begin
            battery_d = battery_q - BATT_W'(1);
        end
        empty_d = (battery_d == '0);
        low_d   = (battery_d <= BATT_W'(LOW_THRESH));
        full_d  = (battery_d == BATT_W'(BATT_MAX));
    end

    // Using empty_d lets a press that coincides with the last drain step be dropped.
    always_comb begin
        gear_d = gear_q;
        if (empty_d && !charge_en) begin
            gear_d = '0;
        end else if (gear_q > gmax) begin
            gear_d = gmax;
        end else if (long_hit) begin
            gear_d = '0;
        end else if (short_press) begin
            gear_d = (gear_q == gmax) ? '0 : gear_q + GW'(1);
        end
    end

    assign drn_en     = !charge_en && (gear_q != '0);
    assign drn_clr    = (gear_d != gear_q) || charge_edge || (gear_q == '0);
    assign drn_period = CNT_W'(drain_period(DRAIN_BASE, 32'(gear_q)));

    // The charge counter idles at 0 while unplugged, so the first step lands CHG_PERIOD cycles after plug-in.
    period_tick #(.W(CNT_W)) u_chg_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (charge_en),
        .clr    (!charge_en),
        .period (CNT_W'(CHG_PERIOD)),
        .wrap   (chg_wrap)
    );

    period_tick #(.W(CNT_W)) u_drn_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (drn_en),
        .clr    (drn_clr),
        .period (drn_period),
        .wrap   (drn_wrap)
    );

    always_comb begin
        led_mode_d = LED_OFF;
        if (charge_en && !full_q) begin
            led_mode_d = LED_BLINK_SLOW;
        end else if (charge_en) begin
            led_mode_d = LED_ON;
        end else if ((gear_q != '0) && low_q) begin
            led_mode_d = LED_BLINK_FAST;
        end else if (gear_q != '0) begin
            led_mode_d = LED_ON;
        end
    end

    assign blink_en     = (led_mode_q == LED_BLINK_SLOW) || (led_mode_q == LED_BLINK_FAST);
    assign blink_clr    = (led_mode_d != led_mode_q);
    assign blink_period = (led_mode_q == LED_BLINK_SLOW) ? CNT_W'(CLK_HZ / 2) : CNT_W'(CLK_HZ / 4);

    period_tick #(.W(CNT_W)) u_blink_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (blink_en),
        .clr    (blink_clr),
        .period (blink_period),
        .wrap   (blink_wrap)
    );

    always_comb begin
        led_d = led_q;
        if (led_mode_d != led_mode_q) begin
            led_d = (led_mode_d != LED_OFF);
        end else if (blink_wrap) begin
            led_d = ~led_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q  <= 1'b0;
            long_done_q <= 1'b0;
            chg_prev_q  <= 1'b0;
            hold_cnt_q  <= '0;
            gear_q      <= '0;
            battery_q   <= BATT_W'(BATT_MAX);
            empty_q     <= 1'b0;
            low_q       <= 1'b0;
            full_q      <= 1'b1;
            led_q       <= 1'b0;
            led_mode_q  <= LED_OFF;
        end else begin
            btn_prev_q  <= btn;
            long_done_q <= long_done_d;
            chg_prev_q  <= charge_en;
            hold_cnt_q  <= hold_cnt_d;
            gear_q      <= gear_d;
            battery_q   <= battery_d;
            empty_q     <= empty_d;
            low_q       <= low_d;
            full_q      <= full_d;
            led_q       <= led_d;
            led_mode_q  <= led_mode_d;
        end
    end

    assign gear          = gear_q;
    assign battery       = battery_q;
    assign battery_empty = empty_q;
    assign battery_low   = low_q;
    assign battery_full  = full_q;
    assign led           = led_q;

endmodule

// File: tb/tb_fan_power_core.sv
// Directed bench for fan_power_core with 4 gears: gear cycling, drain to low/empty,
// long-press power-off, charging to full and asynchronous reset.
module tb_fan_power_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       btn = 1'b0;
    logic       charge_en = 1'b0;
    logic [2:0] gear;
    logic [7:0] battery;
    logic       battery_empty, battery_low, battery_full, led;

    int vectors = 0;
    int miscompares = 0;

    fan_power_core #(
        .CLK_HZ(100), .NUM_GEARS(4), .BATT_W(8), .BATT_MAX(99), .LOW_THRESH(20),
        .LONG_PRESS_TICKS(200), .CHG_PERIOD(50), .DRAIN_BASE(200)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .charge_en     (charge_en),
        .gear          (gear),
        .battery       (battery),
        .battery_empty (battery_empty),
        .battery_low   (battery_low),
        .battery_full  (battery_full),
        .led           (led)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gear"}, 32'(gear), 0);
        check({tag, "_battery"}, 32'(battery), 99);
        check({tag, "_full"}, 32'(battery_full), 1);
        check({tag, "_empty"}, 32'(battery_empty), 0);
        check({tag, "_low"}, 32'(battery_low), 0);
        check({tag, "_led"}, 32'(led), 0);
    endtask

    task automatic press(input int len);
        btn = 1'b1;
        tick(len);
        btn = 1'b0;
        tick(2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        // Reset state, observed before any clock edge
        #2 rst_n = 1'b0;
        #2 check_reset("reset");
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Gear cycling 1..4 then off, no drain in so few cycles
        for (int i = 1; i <= 4; i++) begin
            press(5);
            check("gear_up", 32'(gear), 32'(i));
        end
        press(5);
        check("gear_wrap_off", 32'(gear), 0);
        check("battery_no_drain", 32'(battery), 99);

        // Gear 4 drains 1 per 25 cycles: 79 steps take 99 down to 20
        for (int i = 0; i < 4; i++) press(5);
        check("g4_entry_gear", 32'(gear), 4);
        tick(1973);
        check("g4_batt_21", 32'(battery), 21);
        check("g4_not_low", 32'(battery_low), 0);
        check("g4_led_on", 32'(led), 1);
        tick(1);
        check("g4_batt_20", 32'(battery), 20);
        check("g4_low_set", 32'(battery_low), 1);
        check("g4_gear_before_clamp", 32'(gear), 4);
        tick(1);
        check("low_clamp_gear1", 32'(gear), 1);
        check("fast_led_start", 32'(led), 1);
        tick(24);
        check("fast_led_hold", 32'(led), 1);
        tick(1);
        check("fast_led_toggle0", 32'(led), 0);
        tick(25);
        check("fast_led_toggle1", 32'(led), 1);

        // Long press at gear 3
        do_reset();
        for (int i = 0; i < 3; i++) press(5);
        check("lp_gear3", 32'(gear), 3);
        btn = 1'b1;
        tick(199);
        check("lp_gear_before", 32'(gear), 3);
        check("lp_batt_95", 32'(battery), 95);
        tick(1);
        check("lp_gear_off", 32'(gear), 0);
        btn = 1'b0;
        tick(3);
        check("lp_release_ignored", 32'(gear), 0);
        press(5);
        check("lp_next_press", 32'(gear), 1);

        // Gear 1 drains 95 -> 0 at one step per 200 cycles
        tick(18998);
        check("empty_batt_1", 32'(battery), 1);
        check("empty_gear_1", 32'(gear), 1);
        tick(1);
        check("empty_batt_0", 32'(battery), 0);
        check("empty_flag", 32'(battery_empty), 1);
        check("empty_gear_off", 32'(gear), 0);
        tick(2);
        check("empty_led_off", 32'(led), 0);
        press(5);
        check("empty_press_ignored", 32'(gear), 0);

        // Charge from empty, press accepted while charging
        charge_en = 1'b1;
        tick(49);
        check("chg_batt_0", 32'(battery), 0);
        tick(1);
        check("chg_batt_1", 32'(battery), 1);
        check("chg_not_empty", 32'(battery_empty), 0);
        press(5);
        check("chg_press_gear1", 32'(gear), 1);
        tick(4843);
        check("chg_batt_98", 32'(battery), 98);
        check("slow_led_0", 32'(led), 0);
        tick(1);
        check("slow_led_1", 32'(led), 1);
        tick(48);
        check("chg_not_full", 32'(battery_full), 0);
        tick(1);
        check("chg_batt_99", 32'(battery), 99);
        check("chg_full", 32'(battery_full), 1);
        tick(1);
        check("full_led_on", 32'(led), 1);
        tick(20);
        check("full_led_solid", 32'(led), 1);

        // Asynchronous reset mid-drain at gear 2
        charge_en = 1'b0;
        press(5);
        check("ar_gear2", 32'(gear), 2);
        tick(99);
        check("ar_batt_98", 32'(battery), 98);
        #1 rst_n = 1'b0;
        #1 check_reset("async_reset");
        tick(1);
        rst_n = 1'b1;
        tick(1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
